// File: rtl/md_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, HI/LO select,
// default latencies and the one-shot divide helper.
package md_unit_pkg;

   localparam int unsigned MD_W          = 32;
   localparam int unsigned MD_CNT_W      = 4;
   localparam int unsigned MD_MULT_LAT   = 5;
   localparam int unsigned MD_DIV_LAT    = 10;

   // Bit positions inside the 3-bit op field
   localparam int unsigned MD_MOVE       = 2;
   localparam int unsigned MD_DIVIDE_BIT = 1;
   localparam int unsigned MD_SIGNED_BIT = 0;

   typedef enum logic [2:0] {
      MD_MULTU = 3'b000,
      MD_MULT  = 3'b001,
      MD_DIVU  = 3'b010,
      MD_DIV   = 3'b011
   } md_op_e;

   localparam logic MD_SEL_HI = 1'b0;
   localparam logic MD_SEL_LO = 1'b1;

   // Truncating divide; returns {remainder, quotient}. A zero divisor is
   // replaced by one so the datapath never sees X; the caller discards it.
   function automatic logic [2*MD_W-1:0] md_divide(input logic [MD_W-1:0] a,
                                                   input logic [MD_W-1:0] b,
                                                   input logic            sgn);
      logic            neg_a;
      logic            neg_b;
      logic [MD_W-1:0] mag_a;
      logic [MD_W-1:0] mag_b;
      logic [MD_W-1:0] quo;
      logic [MD_W-1:0] rem;
      neg_a = sgn & a[MD_W-1];
      neg_b = sgn & b[MD_W-1];
      mag_a = neg_a ? (~a + MD_W'(1)) : a;
      mag_b = neg_b ? (~b + MD_W'(1)) : b;
      if (mag_b == '0) begin
         mag_b = MD_W'(1);
      end
      quo = mag_a / mag_b;
      rem = mag_a % mag_b;
      if (neg_a ^ neg_b) begin
         quo = ~quo + MD_W'(1);
      end
      if (neg_a) begin
         rem = ~rem + MD_W'(1);
      end
      return {rem, quo};
   endfunction

endpackage

// File: rtl/md_counter.sv
// Loadable down counter that times a multiply/divide in flight and flags the
// cycle whose closing edge commits the result.
module md_counter
   import md_unit_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                i_load,
   input  logic [MD_CNT_W-1:0] i_load_val,
   output logic                o_busy,
   output logic                o_commit_c
);

   logic [MD_CNT_W-1:0] r_count;
   logic                r_busy;

   // Load on accept, count down while busy, drop busy on the last count
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_count <= '0;
         r_busy  <= 1'b0;
      end else if (i_load) begin
         r_count <= i_load_val;
         r_busy  <= 1'b1;
      end else if (r_count != '0) begin
         r_count <= r_count - MD_CNT_W'(1);
         if (r_count == MD_CNT_W'(1)) begin
            r_busy <= 1'b0;
         end
      end
   end

   assign o_busy     = r_busy;
   assign o_commit_c = r_busy & (r_count == MD_CNT_W'(1));

endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide unit with HI/LO registers, MTHI/MTLO writes and an
// MFHI/MFLO read port. Optional accumulate (madd) is enabled by MDU_MADD_EN.
module md_unit
   import md_unit_pkg::*;
#(
   parameter int unsigned MULT_LAT = MD_MULT_LAT,
   parameter int unsigned DIV_LAT  = MD_DIV_LAT
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic            write,
   input  logic            addr,
   input  logic [MD_W-1:0] rs_data,
   input  logic [MD_W-1:0] rt_data,
   input  logic            flush,
   input  logic            madd,
   output logic            busy,
   output logic [MD_W-1:0] hi,
   output logic [MD_W-1:0] lo,
   output logic [MD_W-1:0] rdata
);

   logic                w_busy;
   logic                w_commit;
   logic                w_accept;
   logic                w_write;
   logic                w_is_div;
   logic                w_div_zero;
   logic [MD_CNT_W-1:0] w_load_val;
   logic [2*MD_W-1:0]   w_a_ext;
   logic [2*MD_W-1:0]   w_b_ext;
   logic [2*MD_W-1:0]   w_prod;
   logic [2*MD_W-1:0]   w_div_res;
   logic [2*MD_W-1:0]   w_result;
   logic [2*MD_W-1:0]   w_commit_val;

   logic [MD_W-1:0]     r_hi;
   logic [MD_W-1:0]     r_lo;
   logic [2*MD_W-1:0]   r_pend;
   logic                r_pend_skip;

   // Accept/write qualification and the result datapath for the incoming op
   always_comb begin
      w_accept   = start & ~flush & ~w_busy & ~op[MD_MOVE];
      w_write    = write & ~flush & ~w_busy & ~w_accept;
      w_is_div   = op[MD_DIVIDE_BIT];
      w_div_zero = w_is_div & (rt_data == '0);
      w_load_val = w_is_div ? MD_CNT_W'(DIV_LAT) : MD_CNT_W'(MULT_LAT);
      w_a_ext    = op[MD_SIGNED_BIT] ? {{MD_W{rs_data[MD_W-1]}}, rs_data}
                                     : {{MD_W{1'b0}}, rs_data};
      w_b_ext    = op[MD_SIGNED_BIT] ? {{MD_W{rt_data[MD_W-1]}}, rt_data}
                                     : {{MD_W{1'b0}}, rt_data};
      // Low 64 bits of the extended product are correct for both signednesses
      w_prod     = w_a_ext * w_b_ext;
      w_div_res  = md_divide(rs_data, rt_data, op[MD_SIGNED_BIT]);
      w_result   = w_is_div ? w_div_res : w_prod;
   end

   md_counter u_counter (
      .clk        (clk),
      .reset      (reset),
      .i_load     (w_accept),
      .i_load_val (w_load_val),
      .o_busy     (w_busy),
      .o_commit_c (w_commit)
   );

`ifdef MDU_MADD_EN
   logic r_pend_madd;

   // Remember whether the accepted multiply accumulates into HI/LO
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_pend_madd <= 1'b0;
      end else if (w_accept) begin
         r_pend_madd <= madd & ~w_is_div;
      end
   end

   assign w_commit_val = r_pend_madd ? ({r_hi, r_lo} + r_pend) : r_pend;
`else
   logic w_unused_madd;
   assign w_unused_madd = madd;
   assign w_commit_val  = r_pend;
`endif

   // Latch pending result on accept; commit or apply MT writes to HI/LO
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_hi        <= '0;
         r_lo        <= '0;
         r_pend      <= '0;
         r_pend_skip <= 1'b0;
      end else begin
         if (w_accept) begin
            r_pend      <= w_result;
            r_pend_skip <= w_div_zero;
         end
         if (w_commit) begin
            if (!r_pend_skip) begin
               {r_hi, r_lo} <= w_commit_val;
            end
         end else if (w_write) begin
            if (addr == MD_SEL_HI) begin
               r_hi <= rs_data;
            end else begin
               r_lo <= rs_data;
            end
         end
      end
   end

   assign busy  = w_busy;
   assign hi    = r_hi;
   assign lo    = r_lo;
   assign rdata = (addr == MD_SEL_LO) ? r_lo : r_hi;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed corner cases plus randomized ops
// checked against an arithmetic reference model of HI/LO.
module tb_md_unit;
   import md_unit_pkg::*;

   localparam int unsigned MULT_LAT = 5;
   localparam int unsigned DIV_LAT  = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic        write;
   logic        addr;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic        flush;
   logic        madd;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [31:0] rdata;

   int          checks   = 0;
   int          failures = 0;
   logic [31:0] m_hi;
   logic [31:0] m_lo;

   md_unit #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .op      (op),
      .write   (write),
      .addr    (addr),
      .rs_data (rs_data),
      .rt_data (rt_data),
      .flush   (flush),
      .madd    (madd),
      .busy    (busy),
      .hi      (hi),
      .lo      (lo),
      .rdata   (rdata)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference result {hi,lo} from plain integer arithmetic; upd=0 means no commit
   task automatic model_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                           output logic upd, output logic [63:0] res);
      longint sa;
      longint sb;
      int     qa;
      int     qb;
      upd = 1'b1;
      res = '0;
      if (!o[1]) begin
         if (o[0]) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
         end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
         end
         res = 64'(sa * sb);
      end else if (b == 32'd0) begin
         upd = 1'b0;
      end else if (o[0]) begin
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            res = {32'd0, 32'h8000_0000};
         end else begin
            qa  = $signed(a);
            qb  = $signed(b);
            res = {32'(qa % qb), 32'(qa / qb)};
         end
      end else begin
         res = {a % b, a / b};
      end
   endtask

   task automatic check_state(input string tag);
      check_eq({tag, "_hi"}, 64'(hi), 64'(m_hi));
      check_eq({tag, "_lo"}, 64'(lo), 64'(m_lo));
   endtask

   task automatic check_rdata();
      addr = MD_SEL_HI;
      #1;
      check_eq("rdata_hi", 64'(rdata), 64'(m_hi));
      addr = MD_SEL_LO;
      #1;
      check_eq("rdata_lo", 64'(rdata), 64'(m_lo));
   endtask

   // Issue one MT write while idle and check the target register
   task automatic do_write(input logic sel, input logic [31:0] data);
      write   = 1'b1;
      addr    = sel;
      rs_data = data;
      tick();
      write = 1'b0;
      if (sel == MD_SEL_HI) m_hi = data;
      else                  m_lo = data;
      check_eq("mt_rdata", 64'(rdata), 64'(data));
      check_state("mt");
   endtask

   // Run one mult/div, poking write/flush/start and scrambling operands while busy
   task automatic run_md(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic md);
      logic        upd;
      logic [63:0] res;
      int          lat;
      model_op(o, a, b, upd, res);
`ifdef MDU_MADD_EN
      if (!o[1] && md) res = res + {m_hi, m_lo};
`endif
      lat     = o[1] ? DIV_LAT : MULT_LAT;
      op      = o;
      rs_data = a;
      rt_data = b;
      madd    = md;
      start   = 1'b1;
      tick();
      start = 1'b0;
      madd  = 1'b0;
      for (int i = 0; i < lat; i++) begin
         check_eq("busy_during", 64'(busy), 64'd1);
         check_state("hold");
         rs_data = $urandom;
         rt_data = $urandom;
         op      = 3'($urandom_range(0, 3));
         addr    = 1'($urandom_range(0, 1));
         write   = (i == 1);
         flush   = (i == 2);
         start   = (i == lat - 1);
         tick();
         write = 1'b0;
         flush = 1'b0;
         start = 1'b0;
      end
      if (upd) {m_hi, m_lo} = res;
      check_eq("busy_done", 64'(busy), 64'd0);
      check_state("commit");
      check_rdata();
   endtask

   initial begin
      logic [2:0]  r_op;
      logic [31:0] r_a;
      logic [31:0] r_b;
      int          kind;

      reset   = 1'b0;
      start   = 1'b0;
      op      = 3'd0;
      write   = 1'b0;
      addr    = 1'b0;
      rs_data = '0;
      rt_data = '0;
      flush   = 1'b0;
      madd    = 1'b0;
      m_hi    = '0;
      m_lo    = '0;
      tick();
      tick();
      check_eq("rst_busy", 64'(busy), 64'd0);
      check_state("rst");
      reset = 1'b1;
      tick();

      // Reset in the middle of a multiply discards it and clears HI/LO
      do_write(MD_SEL_HI, 32'h55);
      do_write(MD_SEL_LO, 32'h66);
      op      = MD_MULT;
      rs_data = 32'd7;
      rt_data = 32'd6;
      start   = 1'b1;
      tick();
      start = 1'b0;
      tick();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      m_hi  = '0;
      m_lo  = '0;
      check_eq("midrst_busy", 64'(busy), 64'd0);
      check_state("midrst");
      repeat (MULT_LAT + 2) tick();
      check_eq("midrst_late_busy", 64'(busy), 64'd0);
      check_state("midrst_late");

      run_md(MD_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
      check_eq("mult_hi_k", 64'(hi), 64'h0000_0000_FFFF_FFFF);
      check_eq("mult_lo_k", 64'(lo), 64'h0000_0000_FFFF_FFFA);
      run_md(MD_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b0);
      check_eq("multu_hi_k", 64'(hi), 64'h0000_0000_0000_0002);
      check_eq("multu_lo_k", 64'(lo), 64'h0000_0000_FFFF_FFFA);
      run_md(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
      check_eq("div_hi_k", 64'(hi), 64'h0000_0000_FFFF_FFFF);
      check_eq("div_lo_k", 64'(lo), 64'h0000_0000_FFFF_FFFD);

      do_write(MD_SEL_HI, 32'h11);
      do_write(MD_SEL_LO, 32'h22);
      run_md(MD_DIVU, 32'd7, 32'd0, 1'b0);
      check_eq("div0_hi_k", 64'(hi), 64'h11);
      check_eq("div0_lo_k", 64'(lo), 64'h22);

      do_write(MD_SEL_HI, 32'hDEAD_BEEF);
      check_rdata();

      // flush together with start suppresses the op
      op      = MD_MULT;
      rs_data = 32'd2;
      rt_data = 32'd2;
      start   = 1'b1;
      flush   = 1'b1;
      tick();
      start = 1'b0;
      flush = 1'b0;
      check_eq("flush_start_busy", 64'(busy), 64'd0);
      check_state("flush_start");
      tick();
      check_eq("flush_start_busy2", 64'(busy), 64'd0);

      // Move-class op with start is not a mult/div
      op    = 3'b100;
      start = 1'b1;
      tick();
      start = 1'b0;
      check_eq("move_start_busy", 64'(busy), 64'd0);
      check_state("move_start");

      run_md(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      check_eq("ovf_hi_k", 64'(hi), 64'h0);
      check_eq("ovf_lo_k", 64'(lo), 64'h8000_0000);

      do_write(MD_SEL_HI, 32'h0);
      do_write(MD_SEL_LO, 32'hFFFF_FFFF);
      run_md(MD_MULTU, 32'd1, 32'd1, 1'b1);
`ifdef MDU_MADD_EN
      check_eq("madd_hi_k", 64'(hi), 64'h1);
      check_eq("madd_lo_k", 64'(lo), 64'h0);
`else
      check_eq("madd_hi_k", 64'(hi), 64'h0);
      check_eq("madd_lo_k", 64'(lo), 64'h1);
`endif

      // Randomized op mix with occasional MT writes in between
      for (int n = 0; n < 40; n++) begin
         kind = $urandom_range(0, 5);
         r_op = 3'($urandom_range(0, 3));
         r_a  = $urandom;
         r_b  = $urandom;
         if (kind == 0) begin
            r_a = 32'($urandom_range(0, 20)) - 32'd10;
            r_b = 32'($urandom_range(0, 20)) - 32'd10;
         end else if (kind == 1) begin
            r_b = 32'd0;
         end else if (kind == 2) begin
            r_a = 32'h8000_0000;
            r_b = 32'hFFFF_FFFF;
         end
         if ($urandom_range(0, 3) == 0) begin
            do_write(1'($urandom_range(0, 1)), $urandom);
         end
         run_md(r_op, r_a, r_b, 1'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
